// File: rtl/xif_coproc_arbiter.sv
// Shares one CORE-V-XIF coprocessor between NUM_CORES cores: round-robin issue arbitration,
// id remapping to {core_idx, core_id}, and per-core commit buffering onto the single commit port.
module xif_coproc_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ID_WIDTH  = 4,
  localparam int CW  = $clog2(NUM_CORES),
  localparam int CIW = CW + ID_WIDTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_CORES-1:0]                 core_issue_valid_i,
  output logic [NUM_CORES-1:0]                 core_issue_ready_o,
  input  logic [NUM_CORES-1:0][31:0]           core_issue_instr_i,
  input  logic [NUM_CORES-1:0][ID_WIDTH-1:0]   core_issue_id_i,
  input  logic [NUM_CORES-1:0][63:0]           core_issue_rs_i,
  input  logic [NUM_CORES-1:0][1:0]            core_issue_rs_valid_i,
  output logic                                 core_issue_accept_o,
  output logic                                 core_issue_wb_o,
  input  logic [NUM_CORES-1:0]                 core_commit_valid_i,
  input  logic [NUM_CORES-1:0][ID_WIDTH-1:0]   core_commit_id_i,
  input  logic [NUM_CORES-1:0]                 core_commit_kill_i,
  output logic [NUM_CORES-1:0]                 core_result_valid_o,
  input  logic [NUM_CORES-1:0]                 core_result_ready_i,
  output logic [ID_WIDTH-1:0]                  core_result_id_o,
  output logic [31:0]                          core_result_data_o,
  output logic [4:0]                           core_result_rd_o,
  output logic                                 core_result_we_o,
  output logic                                 cop_issue_valid_o,
  input  logic                                 cop_issue_ready_i,
  output logic [31:0]                          cop_issue_instr_o,
  output logic [CIW-1:0]                       cop_issue_id_o,
  output logic [63:0]                          cop_issue_rs_o,
  output logic [1:0]                           cop_issue_rs_valid_o,
  input  logic                                 cop_issue_accept_i,
  input  logic                                 cop_issue_wb_i,
  output logic                                 cop_commit_valid_o,
  output logic [CIW-1:0]                       cop_commit_id_o,
  output logic                                 cop_commit_kill_o,
  input  logic                                 cop_result_valid_i,
  output logic                                 cop_result_ready_o,
  input  logic [CIW-1:0]                       cop_result_id_i,
  input  logic [31:0]                          cop_result_data_i,
  input  logic [4:0]                           cop_result_rd_i,
  input  logic                                 cop_result_we_i,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]                          state_q;
  logic [CW-1:0]                       grant_q, rr_ptr_q, cm_ptr_q;
  logic [CW-1:0]                       arb_idx, arb_scan, cur_grant;
  logic                                arb_found;
  logic [CW-1:0]                       send_idx, send_scan;
  logic                                send_found;
  logic [NUM_CORES-1:0]                pend_v, pend_kill;
  logic [NUM_CORES-1:0][ID_WIDTH-1:0]  pend_id;
  logic [CW-1:0]                       res_idx;
  logic                                res_bad;

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    return (v == CW'(NUM_CORES - 1)) ? '0 : v + CW'(1);
  endfunction

  // First requesting core at or after rr_ptr_q, wrapping around.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    arb_scan  = rr_ptr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!arb_found && core_issue_valid_i[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = arb_scan;
      end
      arb_scan = wrap_inc(arb_scan);
    end
  end

  assign cur_grant         = (state_q == LOCKED) ? grant_q : arb_idx;
  assign cop_issue_valid_o = (state_q == LOCKED) ? core_issue_valid_i[grant_q] : arb_found;

  always_comb begin
    core_issue_ready_o            = '0;
    core_issue_ready_o[cur_grant] = cop_issue_valid_o & cop_issue_ready_i;
  end

  assign cop_issue_instr_o    = core_issue_instr_i[cur_grant];
  assign cop_issue_id_o       = {cur_grant, core_issue_id_i[cur_grant]};
  assign cop_issue_rs_o       = core_issue_rs_i[cur_grant];
  assign cop_issue_rs_valid_o = core_issue_rs_valid_i[cur_grant];
  assign core_issue_accept_o  = cop_issue_accept_i;
  assign core_issue_wb_o      = cop_issue_wb_i;

  // A stalled request freezes the grant until the coprocessor takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else if (cop_issue_valid_o) begin
      grant_q <= cur_grant;
      if (cop_issue_ready_i) begin
        state_q  <= IDLE;
        rr_ptr_q <= wrap_inc(cur_grant);
      end else begin
        state_q <= LOCKED;
      end
    end
  end

  always_comb begin
    send_found = 1'b0;
    send_idx   = cm_ptr_q;
    send_scan  = cm_ptr_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!send_found && pend_v[send_scan]) begin
        send_found = 1'b1;
        send_idx   = send_scan;
      end
      send_scan = wrap_inc(send_scan);
    end
  end

  // Captures are written after the send-clear so a same-cycle recapture keeps the entry valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_v             <= '0;
      pend_id            <= '0;
      pend_kill          <= '0;
      cm_ptr_q           <= '0;
      cop_commit_valid_o <= 1'b0;
      cop_commit_id_o    <= '0;
      cop_commit_kill_o  <= 1'b0;
      err_o              <= 1'b0;
    end else begin
      cop_commit_valid_o <= send_found;
      if (send_found) begin
        cop_commit_id_o    <= {send_idx, pend_id[send_idx]};
        cop_commit_kill_o  <= pend_kill[send_idx];
        pend_v[send_idx]   <= 1'b0;
        cm_ptr_q           <= wrap_inc(send_idx);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_commit_valid_i[i]) begin
          pend_v[i]    <= 1'b1;
          pend_id[i]   <= core_commit_id_i[i];
          pend_kill[i] <= core_commit_kill_i[i];
          if (pend_v[i] && !(send_found && send_idx == CW'(i))) err_o <= 1'b1;
        end
      end
      if (cop_result_valid_i && res_bad) err_o <= 1'b1;
    end
  end

  assign res_idx = cop_result_id_i[CIW-1:ID_WIDTH];
  assign res_bad = ({1'b0, res_idx} >= (CW + 1)'(NUM_CORES));

  // Results for a nonexistent core are swallowed so the coprocessor never stalls.
  always_comb begin
    core_result_valid_o = '0;
    cop_result_ready_o  = res_bad;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!res_bad && res_idx == CW'(i)) begin
        core_result_valid_o[i] = cop_result_valid_i;
        cop_result_ready_o     = core_result_ready_i[i];
      end
    end
  end

  assign core_result_id_o   = cop_result_id_i[ID_WIDTH-1:0];
  assign core_result_data_o = cop_result_data_i;
  assign core_result_rd_o   = cop_result_rd_i;
  assign core_result_we_o   = cop_result_we_i;

  assign busy_o = (state_q == LOCKED) | (|pend_v);

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Directed bench for xif_coproc_arbiter (3 cores) with a behavioural reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_xif_coproc_arbiter;

  localparam int N   = 3;
  localparam int IW  = 4;
  localparam int CW  = 2;
  localparam int CIW = CW + IW;

  logic clk, rst;
  logic [N-1:0]          c_iv, c_ir;
  logic [N-1:0][31:0]    c_instr;
  logic [N-1:0][IW-1:0]  c_iid;
  logic [N-1:0][63:0]    c_rs;
  logic [N-1:0][1:0]     c_rsv;
  logic                  c_acc, c_wb;
  logic [N-1:0]          c_cv, c_ck;
  logic [N-1:0][IW-1:0]  c_cid;
  logic [N-1:0]          r_v, r_rdy;
  logic [IW-1:0]         r_id;
  logic [31:0]           r_data;
  logic [4:0]            r_rd;
  logic                  r_we;
  logic                  p_iv, p_ir, p_acc, p_wb;
  logic [31:0]           p_instr;
  logic [CIW-1:0]        p_iid;
  logic [63:0]           p_rs;
  logic [1:0]            p_rsv;
  logic                  p_cv, p_ck;
  logic [CIW-1:0]        p_cid;
  logic                  p_rv, p_rrdy, p_rwe;
  logic [CIW-1:0]        p_rid;
  logic [31:0]           p_rdata;
  logic [4:0]            p_rrd;
  logic                  busy, err;

  int tests = 0;
  int fails = 0;

  xif_coproc_arbiter #(.NUM_CORES(N), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_issue_valid_i(c_iv), .core_issue_ready_o(c_ir), .core_issue_instr_i(c_instr),
    .core_issue_id_i(c_iid), .core_issue_rs_i(c_rs), .core_issue_rs_valid_i(c_rsv),
    .core_issue_accept_o(c_acc), .core_issue_wb_o(c_wb),
    .core_commit_valid_i(c_cv), .core_commit_id_i(c_cid), .core_commit_kill_i(c_ck),
    .core_result_valid_o(r_v), .core_result_ready_i(r_rdy), .core_result_id_o(r_id),
    .core_result_data_o(r_data), .core_result_rd_o(r_rd), .core_result_we_o(r_we),
    .cop_issue_valid_o(p_iv), .cop_issue_ready_i(p_ir), .cop_issue_instr_o(p_instr),
    .cop_issue_id_o(p_iid), .cop_issue_rs_o(p_rs), .cop_issue_rs_valid_o(p_rsv),
    .cop_issue_accept_i(p_acc), .cop_issue_wb_i(p_wb),
    .cop_commit_valid_o(p_cv), .cop_commit_id_o(p_cid), .cop_commit_kill_o(p_ck),
    .cop_result_valid_i(p_rv), .cop_result_ready_o(p_rrdy), .cop_result_id_i(p_rid),
    .cop_result_data_i(p_rdata), .cop_result_rd_i(p_rrd), .cop_result_we_i(p_rwe),
    .busy_o(busy), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit            model_on = 1'b0;
  bit            m_locked, m_cv, m_ck, m_err;
  int            m_grant, m_rr, m_cptr;
  bit            m_pv[N];
  bit            m_pk[N];
  logic [IW-1:0] m_pid[N];
  logic [CIW-1:0] m_cid;

  // Closest requester in round-robin distance from m_rr, unless a grant is held.
  function automatic void issueSel(output bit v, output int g);
    int best;
    v = 1'b0;
    g = 0;
    best = N;
    if (m_locked) begin
      g = m_grant;
      v = c_iv[m_grant];
    end else begin
      for (int c = 0; c < N; c++) begin
        if (c_iv[c] && ((c - m_rr + N) % N) < best) begin
          best = (c - m_rr + N) % N;
          g = c;
          v = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    bit v;
    int g, sc, best, idx;
    if (rst) begin
      m_locked = 0; m_grant = 0; m_rr = 0; m_cptr = 0;
      m_cv = 0; m_ck = 0; m_cid = '0; m_err = 0;
      for (int c = 0; c < N; c++) begin m_pv[c] = 0; m_pk[c] = 0; m_pid[c] = '0; end
      model_on = 1'b1;
    end else if (model_on) begin
      issueSel(v, g);
      sc = -1;
      best = N;
      for (int c = 0; c < N; c++)
        if (m_pv[c] && ((c - m_cptr + N) % N) < best) begin
          best = (c - m_cptr + N) % N;
          sc = c;
        end
      idx = int'(p_rid[CIW-1:IW]);
      if (p_rv && idx >= N) m_err = 1;
      if (v && p_ir) begin m_locked = 0; m_rr = (g + 1) % N; end
      else if (v) begin m_locked = 1; m_grant = g; end
      if (sc >= 0) begin
        m_cv = 1; m_cid = {CW'(sc), m_pid[sc]}; m_ck = m_pk[sc];
        m_pv[sc] = 0; m_cptr = (sc + 1) % N;
      end else begin
        m_cv = 0;
      end
      for (int c = 0; c < N; c++)
        if (c_cv[c]) begin
          if (m_pv[c]) m_err = 1;
          m_pv[c] = 1; m_pid[c] = c_cid[c]; m_pk[c] = c_ck[c];
        end
    end
  end

  always @(negedge clk) begin
    bit v, anyp;
    int g, idx;
    if (model_on) begin
      issueSel(v, g);
      checkOutput("issue_valid", 64'(p_iv), 64'(v));
      if (v) begin
        checkOutput("issue_id", 64'(p_iid), 64'({g[CW-1:0], c_iid[g]}));
        checkOutput("issue_instr", 64'(p_instr), 64'(c_instr[g]));
        checkOutput("issue_rs", p_rs, c_rs[g]);
        checkOutput("issue_rs_valid", 64'(p_rsv), 64'(c_rsv[g]));
      end
      checkOutput("core_ready", 64'(c_ir), (v && p_ir) ? 64'(1) << g : 64'(0));
      checkOutput("accept_wb", 64'({c_acc, c_wb}), 64'({p_acc, p_wb}));
      checkOutput("commit_valid", 64'(p_cv), 64'(m_cv));
      if (m_cv) checkOutput("commit_id_kill", 64'({p_cid, p_ck}), 64'({m_cid, m_ck}));
      idx = int'(p_rid[CIW-1:IW]);
      checkOutput("result_valid", 64'(r_v), (p_rv && idx < N) ? 64'(1) << idx : 64'(0));
      checkOutput("result_ready", 64'(p_rrdy), (idx >= N) ? 64'(1) : 64'(r_rdy[idx]));
      checkOutput("result_bcast", 64'({r_id, r_data, r_rd, r_we}),
                  64'({p_rid[IW-1:0], p_rdata, p_rrd, p_rwe}));
      anyp = 0;
      for (int c = 0; c < N; c++) anyp |= m_pv[c];
      checkOutput("busy", 64'(busy), 64'(m_locked | anyp));
      checkOutput("err", 64'(err), 64'(m_err));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] iv, input logic ir,
                               input logic [N-1:0] cv, input logic [N-1:0] rrdy);
    c_iv = iv; p_ir = ir; c_cv = cv; r_rdy = rrdy;
  endtask

  task automatic nextCycle();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    c_iv = '0; c_cv = '0; c_ck = '0; r_rdy = '0; p_ir = 0; p_acc = 0; p_wb = 0;
    p_rv = 0; p_rid = '0; p_rdata = '0; p_rrd = '0; p_rwe = 0;
    c_iid = '0; c_cid = '0;
    for (int c = 0; c < N; c++) begin
      c_instr[c] = 32'h1000_0000 + 32'(c);
      c_rs[c]    = {32'hA0 + 32'(c), 32'hB0 + 32'(c)};
      c_rsv[c]   = 2'(c + 1);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    probe();
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_err", 64'(err), 64'(0));
    checkOutput("reset_commit_valid", 64'(p_cv), 64'(0));
    checkOutput("reset_issue_valid", 64'(p_iv), 64'(0));
    nextCycle();

    // Simultaneous requests: core0 first, core1 next
    c_iid[0] = 4'd2; c_iid[1] = 4'd5; p_acc = 1; p_wb = 1;
    applyStimulus(3'b011, 1'b1, 3'b000, 3'b000);
    probe();
    checkOutput("rr_first_id", 64'(p_iid), 64'(6'h02));
    checkOutput("rr_first_ready", 64'(c_ir), 64'(3'b001));
    nextCycle();
    applyStimulus(3'b010, 1'b1, 3'b000, 3'b000);
    probe();
    checkOutput("rr_second_id", 64'(p_iid), 64'(6'h15));
    checkOutput("rr_second_ready", 64'(c_ir), 64'(3'b010));
    nextCycle();

    // Stalled core1 keeps the grant while core0 waits
    c_iid[1] = 4'd7; c_iid[0] = 4'd1; p_acc = 0;
    applyStimulus(3'b010, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("lock_id0", 64'(p_iid), 64'(6'h17));
    nextCycle();
    applyStimulus(3'b011, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("lock_id1", 64'(p_iid), 64'(6'h17));
    checkOutput("lock_busy", 64'(busy), 64'(1));
    nextCycle();
    probe();
    checkOutput("lock_ready_low", 64'(c_ir), 64'(0));
    nextCycle();
    applyStimulus(3'b011, 1'b1, 3'b000, 3'b000);
    probe();
    checkOutput("lock_release", 64'(c_ir), 64'(3'b010));
    nextCycle();
    applyStimulus(3'b001, 1'b1, 3'b000, 3'b000);
    probe();
    checkOutput("after_lock_id", 64'(p_iid), 64'(6'h01));
    nextCycle();

    // Two commits in one cycle serialise onto consecutive cycles
    c_cid[0] = 4'd3; c_cid[1] = 4'd5;
    applyStimulus(3'b000, 1'b0, 3'b011, 3'b000);
    probe();
    nextCycle();
    applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("commit_wait", 64'(p_cv), 64'(0));
    checkOutput("commit_busy", 64'(busy), 64'(1));
    nextCycle();
    probe();
    checkOutput("commit_first", 64'({p_cv, p_cid}), 64'({1'b1, 6'h03}));
    nextCycle();
    probe();
    checkOutput("commit_second", 64'({p_cv, p_cid}), 64'({1'b1, 6'h15}));
    nextCycle();
    probe();
    checkOutput("commit_drained", 64'(p_cv), 64'(0));

    // Recapture on the cycle its entry is being sent: both values go out, no error
    nextCycle();
    c_cid[0] = 4'd9;
    applyStimulus(3'b000, 1'b0, 3'b001, 3'b000);
    nextCycle();
    c_cid[0] = 4'd10;
    nextCycle();
    applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("recapture_first", 64'(p_cid), 64'(6'h09));
    checkOutput("recapture_no_err", 64'(err), 64'(0));
    nextCycle();
    probe();
    checkOutput("recapture_second", 64'(p_cid), 64'(6'h0A));
    nextCycle();

    // Result to core1 with core1 stalling two cycles
    p_rv = 1; p_rid = 6'h14; p_rdata = 32'hCAFE_0001; p_rrd = 5'd9; p_rwe = 1;
    applyStimulus(3'b000, 1'b0, 3'b000, 3'b101);
    probe();
    checkOutput("result_stall0", 64'({p_rrdy, r_v}), 64'({1'b0, 3'b010}));
    checkOutput("result_id", 64'(r_id), 64'(4'h4));
    nextCycle();
    probe();
    checkOutput("result_stall1", 64'(p_rrdy), 64'(0));
    nextCycle();
    applyStimulus(3'b000, 1'b0, 3'b000, 3'b111);
    probe();
    checkOutput("result_go", 64'({p_rrdy, r_v}), 64'({1'b1, 3'b010}));
    nextCycle();

    // Out-of-range result index is dropped and flagged
    p_rid = 6'h30;
    applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("bad_idx_drop", 64'({p_rrdy, r_v}), 64'({1'b1, 3'b000}));
    nextCycle();
    p_rv = 0; p_rid = '0;
    probe();
    checkOutput("bad_idx_err", 64'(err), 64'(1));
    nextCycle();
    nextCycle();
    probe();
    checkOutput("bad_idx_sticky", 64'(err), 64'(1));
    nextCycle();

    // Reset while locked with a commit pending
    c_iid[2] = 4'd6; c_cid[2] = 4'd11; c_ck[2] = 1'b1;
    applyStimulus(3'b100, 1'b0, 3'b100, 3'b000);
    probe();
    checkOutput("pre_reset_id", 64'(p_iid), 64'(6'h26));
    nextCycle();
    rst = 1'b1;
    applyStimulus(3'b101, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("pre_reset_busy", 64'(busy), 64'(1));
    nextCycle();
    rst = 1'b0;
    probe();
    checkOutput("post_reset_state", 64'({busy, p_cv, err}), 64'(0));
    checkOutput("post_reset_core0", 64'({p_iv, p_iid}), 64'({1'b1, 6'h01}));
    nextCycle();
    applyStimulus(3'b101, 1'b1, 3'b000, 3'b000);
    probe();
    checkOutput("post_reset_ready", 64'(c_ir), 64'(3'b001));
    nextCycle();
    applyStimulus(3'b100, 1'b1, 3'b000, 3'b000);
    probe();
    checkOutput("post_reset_core2", 64'(c_ir), 64'(3'b100));
    nextCycle();

    // Commit overflow: core1 recommits while core0 is the one being sent
    c_ck[2] = 1'b0; c_cid[0] = 4'd1; c_cid[1] = 4'd2;
    applyStimulus(3'b000, 1'b0, 3'b011, 3'b000);
    nextCycle();
    c_cid[1] = 4'd4;
    applyStimulus(3'b000, 1'b0, 3'b010, 3'b000);
    probe();
    checkOutput("overflow_before", 64'(err), 64'(0));
    nextCycle();
    applyStimulus(3'b000, 1'b0, 3'b000, 3'b000);
    probe();
    checkOutput("overflow_err", 64'(err), 64'(1));
    repeat (5) nextCycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
